// File: rtl/del_pkg.sv
// Shared types and constants for the delay-line read engine.
package del_pkg;

    // Read sequence: accept strobe, issue RAM read, wait for data, present output.
    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWait,
        StOut
    } del_rd_state_t;

    // Cycles from an accepted strobe to the matching vld_o pulse.
    localparam int unsigned DEL_RD_LAT = 3;

endpackage

// File: rtl/dly_ramp.sv
// Slew limiter for the read delay: moves the current delay toward the target by at
// most DLY_STEP per accepted strobe, never overshooting, and treats a target of 0 as 1.
module dly_ramp
    import del_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DLY_STEP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] tgt,
    output logic [ADDR_WIDTH-1:0] cur
);

    localparam int unsigned MaxDly   = (2 ** ADDR_WIDTH) - 1;
    // A step wider than the delay range behaves like an immediate jump.
    localparam int unsigned StepClip = (DLY_STEP > MaxDly) ? MaxDly : DLY_STEP;
    localparam logic [ADDR_WIDTH-1:0] Step   = ADDR_WIDTH'(StepClip);
    localparam logic [ADDR_WIDTH-1:0] DlyOne = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] tgt_eff;
    logic [ADDR_WIDTH-1:0] gap;
    logic [ADDR_WIDTH-1:0] delta;
    logic [ADDR_WIDTH-1:0] cur_q;
    logic [ADDR_WIDTH-1:0] cur_d;

    // Next delay: close the gap to the clamped target by at most one step.
    always_comb begin
        tgt_eff = (tgt == '0) ? DlyOne : tgt;
        gap     = '0;
        delta   = '0;
        cur_d   = cur_q;
        if (step) begin
            if (cur_q < tgt_eff) begin
                gap   = tgt_eff - cur_q;
                delta = (gap > Step) ? Step : gap;
                cur_d = cur_q + delta;
            end else if (cur_q > tgt_eff) begin
                gap   = cur_q - tgt_eff;
                delta = (gap > Step) ? Step : gap;
                cur_d = cur_q - delta;
            end
        end
    end

    // Current delay register; restarts at the minimum delay of one sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= DlyOne;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign cur = cur_q;

endmodule

// File: rtl/del_rd.sv
// Read-side engine of the circular delay buffer: for each accepted strobe, reads the
// sample written cur_dly strobes earlier and presents it to the wet-path mixer.
module del_rd
    import del_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DLY_STEP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  vld_i,
    input  logic [ADDR_WIDTH-1:0] wr_ptr_i,
    input  logic [ADDR_WIDTH-1:0] dly_i,
    output logic                  mem_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  vld_o,
    output logic [ADDR_WIDTH-1:0] dly_o,
    output logic                  busy_o,
    output logic                  ovf_o
);

    localparam logic [ADDR_WIDTH:0] FillOne = (ADDR_WIDTH + 1)'(1);

    del_rd_state_t state_q, state_d;

    logic                  accept;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] cur_dly;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic                  fill_hit;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ovf_q, ovf_d;

    assign accept = en & vld_i & (state_q == StIdle);
    assign drop   = en & vld_i & (state_q != StIdle);

    dly_ramp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DLY_STEP   (DLY_STEP)
    ) u_dly_ramp (
        .clk  (clk),
        .rst  (rst),
        .step (accept),
        .tgt  (dly_i),
        .cur  (cur_dly)
    );

    // Natural ADDR_WIDTH-bit wrap gives the circular-buffer address.
    assign rd_addr = wr_ptr_q - cur_dly;

    // A location is valid only once more strobes have been accepted than the delay.
    assign fill_hit = (fill_q > {1'b0, cur_dly});

    // Sequence FSM: only the exit from idle is conditional.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRd;
            StRd:    state_d = StWait;
            StWait:  state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: pointer latch, address hold, fill count, output data, overflow.
    always_comb begin
        wr_ptr_d   = accept ? wr_ptr_i : wr_ptr_q;
        mem_addr_d = (state_q == StRd) ? rd_addr : mem_addr_q;
        fill_d     = fill_q;
        if (accept && !fill_q[ADDR_WIDTH]) begin
            fill_d = fill_q + FillOne;
        end
        data_d = data_q;
        if (state_q == StWait) begin
            data_d = fill_hit ? mem_data_i : '0;
        end
        ovf_d = ovf_q | drop;
    end

    // State and datapath registers; reset abandons any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            mem_addr_q <= '0;
            fill_q     <= '0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_addr_q <= mem_addr_d;
            fill_q     <= fill_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
        end
    end

    // Outputs decoded from the state register so they clear with it on reset.
    always_comb begin
        mem_rd_o   = (state_q == StRd);
        mem_addr_o = (state_q == StRd) ? rd_addr : mem_addr_q;
        vld_o      = (state_q == StOut);
        busy_o     = (state_q != StIdle);
        data_o     = data_q;
        dly_o      = cur_dly;
        ovf_o      = ovf_q;
    end

endmodule

// File: tb/tb_del_rd.sv
// Self-checking bench for del_rd with a behavioural RAM, a writer model and a
// strobe-history reference model.
module tb_del_rd;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int STEP = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          en;
    logic          vld_i;
    logic [AW-1:0] wr_ptr_i;
    logic [AW-1:0] dly_i;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_i;
    logic [DW-1:0] data_o;
    logic          vld_o;
    logic [AW-1:0] dly_o;
    logic          busy_o;
    logic          ovf_o;

    int n_cmp;
    int n_err;

    // Writer and RAM models.
    logic [AW-1:0] wp;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ram [DEPTH];

    // Reference model: samples in strobe order since reset.
    logic [DW-1:0] hist [$];
    int            n_acc;
    int            mcur;

    del_rd #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DLY_STEP   (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .vld_i      (vld_i),
        .wr_ptr_i   (wr_ptr_i),
        .dly_i      (dly_i),
        .mem_rd_o   (mem_rd_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .data_o     (data_o),
        .vld_o      (vld_o),
        .dly_o      (dly_o),
        .busy_o     (busy_o),
        .ovf_o      (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vld_i) ram[wr_ptr_i] <= wdata;
        if (mem_rd_o) mem_data_i <= ram[mem_addr_o];
    end

    task automatic model_reset();
        hist.delete();
        n_acc = 0;
        mcur  = 1;
    endtask

    task automatic model_accept(input int dly, input logic [DW-1:0] s, input logic [AW-1:0] ptr,
                                output logic [DW-1:0] exp_d, output logic [AW-1:0] exp_a,
                                output logic [AW-1:0] exp_dly);
        int t;
        t = (dly == 0) ? 1 : dly;
        if (mcur < t) mcur = mcur + (((t - mcur) < STEP) ? (t - mcur) : STEP);
        else if (mcur > t) mcur = mcur - (((mcur - t) < STEP) ? (mcur - t) : STEP);
        hist.push_back(s);
        if (n_acc < DEPTH) n_acc++;
        exp_d   = (n_acc > mcur) ? hist[hist.size() - 1 - mcur] : '0;
        exp_a   = AW'(int'(ptr) - mcur);
        exp_dly = AW'(mcur);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        vld_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one strobe and captures what the DUT does with it (no checking here).
    task automatic do_strobe(input logic [AW-1:0] dly, input logic [DW-1:0] s,
                             output logic [DW-1:0] dout, output logic [AW-1:0] addr,
                             output logic [AW-1:0] dly_seen, output logic rd_seen,
                             output int lat);
        @(negedge clk);
        en       = 1'b1;
        vld_i    = 1'b1;
        dly_i    = dly;
        wr_ptr_i = wp;
        wdata    = s;
        @(negedge clk);
        vld_i    = 1'b0;
        wp       = wp + 1'b1;
        lat      = 1;
        rd_seen  = mem_rd_o;
        addr     = mem_addr_o;
        dly_seen = dly_o;
        while (!vld_o && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        dout = data_o;
    endtask

    task automatic test_reset();
        logic [DW-1:0] dout, ed;
        logic [AW-1:0] addr, ea, dseen, edly;
        logic          rds;
        int            lat, pulses;
        rst = 1'b1; en = 1'b0; vld_i = 1'b0; dly_i = '0; wr_ptr_i = '0; wdata = '0; wp = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (data_o !== '0) begin n_err++; $display("FAIL rst_data got %0d want 0", data_o); end
        n_cmp++; if (vld_o !== 1'b0) begin n_err++; $display("FAIL rst_vld got %0b want 0", vld_o); end
        n_cmp++; if (mem_rd_o !== 1'b0) begin n_err++; $display("FAIL rst_rd got %0b want 0", mem_rd_o); end
        n_cmp++; if (mem_addr_o !== '0) begin n_err++; $display("FAIL rst_addr got %0d want 0", mem_addr_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b want 0", busy_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %0b want 0", ovf_o); end
        n_cmp++; if (dly_o !== 4'd1) begin n_err++; $display("FAIL rst_dly got %0d want 1", dly_o); end
        // Strobe in the same cycle as reset is discarded.
        en = 1'b1; vld_i = 1'b1; dly_i = 4'd7; wr_ptr_i = wp; wdata = 16'h1111;
        @(negedge clk);
        rst = 1'b0; vld_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_strobe_busy got %0b want 0", busy_o); end
        n_cmp++; if (dly_o !== 4'd1) begin n_err++; $display("FAIL rst_strobe_dly got %0d want 1", dly_o); end
        // Reset while the read sequence is waiting on RAM data.
        vld_i = 1'b1; dly_i = 4'd5; wr_ptr_i = wp; wdata = 16'h2222;
        @(negedge clk);
        vld_i = 1'b0; wp = wp + 1'b1;
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL mid_busy got %0b want 1", busy_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (data_o !== '0 || vld_o !== 1'b0 || mem_rd_o !== 1'b0 || mem_addr_o !== '0 ||
            busy_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_outs got d=%0d v=%0b r=%0b a=%0d b=%0b o=%0b want all 0",
                     data_o, vld_o, mem_rd_o, mem_addr_o, busy_o, ovf_o);
        end
        n_cmp++; if (dly_o !== 4'd1) begin n_err++; $display("FAIL mid_rst_dly got %0d want 1", dly_o); end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (vld_o) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL mid_rst_novld got %0d want 0", pulses); end
        model_accept(2, 16'h3333, wp, ed, ea, edly);
        do_strobe(4'd2, 16'h3333, dout, addr, dseen, rds, lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL post_rst_lat got %0d want 3", lat); end
        n_cmp++; if (dout !== ed) begin n_err++; $display("FAIL post_rst_data got %0d want %0d", dout, ed); end
        n_cmp++; if (addr !== ea) begin n_err++; $display("FAIL post_rst_addr got %0d want %0d", addr, ea); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] dout, ed;
        logic [AW-1:0] addr, ea, dseen, edly;
        logic          rds;
        int            lat;
        do_reset();
        wp = 4'd13;
        for (int i = 0; i < 20; i++) begin
            model_accept(3, DW'(i + 1), wp, ed, ea, edly);
            do_strobe(4'd3, DW'(i + 1), dout, addr, dseen, rds, lat);
            repeat (4) @(negedge clk);
            n_cmp++;
            if (lat !== 3) begin n_err++; $display("FAIL basic_lat[%0d] got %0d want 3", i, lat); end
            n_cmp++;
            if (rds !== 1'b1) begin n_err++; $display("FAIL basic_rd[%0d] got %0b want 1", i, rds); end
            n_cmp++;
            if (dout !== ((i < 3) ? DW'(0) : DW'(i - 2))) begin
                n_err++;
                $display("FAIL basic_data[%0d] got %0d want %0d", i, dout, (i < 3) ? 0 : i - 2);
            end
            n_cmp++;
            if (addr !== ea) begin n_err++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, addr, ea); end
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] dout, ed, ram14;
        logic [AW-1:0] addr, ea, dseen, edly;
        logic          rds;
        int            lat;
        ram14 = ram[14];
        model_accept(3, 16'h00aa, wp, ed, ea, edly);
        do_strobe(4'd3, 16'h00aa, dout, addr, dseen, rds, lat);
        n_cmp++; if (addr !== 4'd14) begin n_err++; $display("FAIL wrap_addr got %0d want 14", addr); end
        n_cmp++; if (dout !== ram14) begin n_err++; $display("FAIL wrap_ram got %0d want %0d", dout, ram14); end
        n_cmp++; if (dout !== ed) begin n_err++; $display("FAIL wrap_model got %0d want %0d", dout, ed); end
    endtask

    task automatic test_ramp();
        logic [DW-1:0] dout, ed;
        logic [AW-1:0] addr, ea, dseen, edly;
        logic          rds;
        int            lat;
        int            dly_tab [7] = '{10, 10, 10, 10, 0, 0, 0};
        int            exp_tab [7] = '{5, 9, 10, 10, 6, 2, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            model_accept(dly_tab[i], DW'($urandom), wp, ed, ea, edly);
            do_strobe(AW'(dly_tab[i]), hist[hist.size() - 1], dout, addr, dseen, rds, lat);
            n_cmp++;
            if (dseen !== AW'(exp_tab[i])) begin
                n_err++;
                $display("FAIL ramp_dly[%0d] got %0d want %0d", i, dseen, exp_tab[i]);
            end
            n_cmp++;
            if (dout !== ed) begin n_err++; $display("FAIL ramp_data[%0d] got %0d want %0d", i, dout, ed); end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] dout, ed, s;
        logic [AW-1:0] addr, ea, dseen, edly;
        logic          rds;
        int            lat, d;
        for (int i = 0; i < 40; i++) begin
            d = $urandom_range(0, 15);
            s = DW'($urandom);
            model_accept(d, s, wp, ed, ea, edly);
            do_strobe(AW'(d), s, dout, addr, dseen, rds, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_cmp++;
            if (dout !== ed) begin n_err++; $display("FAIL rand_data[%0d] got %0d want %0d", i, dout, ed); end
            n_cmp++;
            if (addr !== ea) begin n_err++; $display("FAIL rand_addr[%0d] got %0d want %0d", i, addr, ea); end
            n_cmp++;
            if (dseen !== edly) begin n_err++; $display("FAIL rand_dly[%0d] got %0d want %0d", i, dseen, edly); end
            n_cmp++;
            if (lat !== 3) begin n_err++; $display("FAIL rand_lat[%0d] got %0d want 3", i, lat); end
        end
    endtask

    task automatic test_overflow();
        int pulses, rds;
        do_reset();
        // Second strobe lands in RD and must be dropped.
        @(negedge clk);
        en = 1'b1; vld_i = 1'b1; dly_i = 4'd2; wr_ptr_i = wp; wdata = 16'h0bad;
        pulses = 0;
        @(negedge clk);
        wr_ptr_i = wp + 1'b1;
        @(negedge clk);
        vld_i = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (vld_o) pulses++;
        end
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL ovf_pulses got %0d want 1", pulses); end
        n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_set got %0b want 1", ovf_o); end
        repeat (5) @(negedge clk);
        n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %0b want 1", ovf_o); end
        // Enable low: strobes ignored, including ones while busy.
        do_reset();
        en = 1'b0;
        rds = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vld_i = (i % 3 != 2);
            if (mem_rd_o) rds++;
        end
        vld_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_rd_o) rds++;
        end
        n_cmp++; if (rds !== 0) begin n_err++; $display("FAIL en0_rd got %0d want 0", rds); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL en0_ovf got %0b want 0", ovf_o); end
        // Sequence already in flight finishes after enable drops.
        @(negedge clk);
        en = 1'b1; vld_i = 1'b1;
        @(negedge clk);
        en = 1'b0; vld_i = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (vld_o) pulses++;
        end
        vld_i = 1'b0;
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL en0_inflight got %0d want 1", pulses); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL en0_drop_ovf got %0b want 0", ovf_o); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_basic();
        test_wrap();
        test_ramp();
        test_random();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
